// File: rtl/camera_emulator.sv
// Synthetic OV7670-style parallel camera source: drives pclk (clk/2), vsync,
// href and RGB565 bytes (high byte first) from one of four test patterns.
module camera_emulator #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 288,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_start,
  output logic [15:0] frame_count,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam logic [10:0] LINE_M1   = 11'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [10:0] ACT_BYTES = 11'(2 * H_ACTIVE);
  localparam logic [9:0]  VS_M1     = 10'(V_SYNC - 1);
  localparam logic [9:0]  VB_M1     = 10'(V_BACK - 1);
  localparam logic [9:0]  VA_M1     = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VF_M1     = 10'(V_FRONT - 1);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t      state, nstate;
  logic [10:0] bc, nbc;
  logic [9:0]  lc, nlc, lines_m1;
  logic        end_line, frame_end, start_frame, nhref;
  logic [1:0]  pat;
  logic [15:0] solid, pidx, pix;
  logic [9:0]  x;
  logic [12:0] bar_q;
  logic [7:0]  byte_sel;

  assign dbg_state = state;

  function automatic logic [15:0] bar_colour(input logic [2:0] b);
    case (b)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // bc/lc always name the byte currently on the bus; the next position is
  // computed here so outputs can be registered for it on the update edge.
  always_comb begin
    nstate    = state;
    nbc       = bc;
    nlc       = lc;
    frame_end = 1'b0;
    end_line  = (bc == LINE_M1);
    case (state)
      S_VSYNC:  lines_m1 = VS_M1;
      S_VBACK:  lines_m1 = VB_M1;
      S_ACTIVE: lines_m1 = VA_M1;
      default:  lines_m1 = VF_M1;
    endcase
    if (state == S_IDLE) begin
      if (enable) begin
        nstate = S_VSYNC;
        nbc    = '0;
        nlc    = '0;
      end
    end else begin
      nbc = end_line ? 11'd0 : bc + 11'd1;
      nlc = end_line ? lc + 10'd1 : lc;
      if (end_line && lc == lines_m1) begin
        nlc = '0;
        case (state)
          S_VSYNC:  nstate = S_VBACK;
          S_VBACK:  nstate = S_ACTIVE;
          S_ACTIVE: nstate = S_VFRONT;
          default: begin
            frame_end = 1'b1;
            nstate    = enable ? S_VSYNC : S_IDLE;
          end
        endcase
      end
    end
    start_frame = enable && (state == S_IDLE || frame_end);
  end

  // Pixel for the next byte position, from the per-frame latched pattern.
  always_comb begin
    nhref = (nstate == S_ACTIVE) && (nbc < ACT_BYTES);
    x     = nbc[10:1];
    bar_q = {x, 3'b000} / 13'(H_ACTIVE);
    case (pat)
      2'd0:    pix = bar_colour(bar_q[2:0]);
      2'd1:    pix = pidx;
      2'd2:    pix = solid;
      default: pix = (x[3] ^ nlc[3]) ? 16'hFFFF : 16'h0000;
    endcase
    byte_sel = nbc[0] ? pix[7:0] : pix[15:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pclk        <= 1'b0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      p_data      <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
      state       <= S_IDLE;
      bc          <= '0;
      lc          <= '0;
      pat         <= '0;
      solid       <= '0;
      pidx        <= '0;
    end else begin
      pclk        <= ~pclk;
      frame_start <= 1'b0;
      if (pclk) begin
        state  <= nstate;
        bc     <= nbc;
        lc     <= nlc;
        vsync  <= (nstate == S_VSYNC);
        href   <= nhref;
        p_data <= nhref ? byte_sel : 8'h00;
        busy   <= (nstate != S_IDLE);
        if (start_frame) begin
          frame_start <= 1'b1;
          pat         <= pattern_sel;
          solid       <= solid_rgb;
          pidx        <= '0;
        end else if (nhref && nbc[0]) begin
          pidx <= pidx + 16'd1;
        end
        if (frame_end) frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
